// File: rtl/ibus_sram_if_pkg.sv
// ---------------------------------------------------------------------------
// ibus_sram_if_pkg
//   Shared widths, constants and state encoding for the instruction-side
//   SRAM bus bridge (ibus_sram_if).
//   Contents:
//     ADDR_W / DATA_W : physical address and instruction word widths
//     ZERO_WORD       : value driven on ibus_rdata when no word is delivered
//     ibs_state_e     : bridge states IDLE / ADDR / DATA / HOLD
// ---------------------------------------------------------------------------
package ibus_sram_if_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no transaction outstanding
    ST_ADDR = 2'd1,  // request issued, waiting for address acceptance
    ST_DATA = 2'd2,  // address accepted, waiting for read data
    ST_HOLD = 2'd3   // word delivered, held while the pipeline is stalled
  } ibs_state_e;

endpackage

// File: rtl/ibus_sram_if.sv
// ---------------------------------------------------------------------------
// ibus_sram_if
//   Instruction fetch bridge between the instruction MMU and a split
//   address/data SRAM-like master port. One outstanding transaction at most;
//   the fetch stage is stalled until the word arrives and the word is held
//   while the pipeline is stalled by another source.
//
//   Optional feature: define IBUS_BUF_EN to add a one-entry fetch buffer
//   {valid, tag, data} that serves repeat fetches of the last address
//   without touching the bus. Without it, ibuf_inv is unused.
//
//   Ports:
//     clk         in   1   rising-edge clock
//     resetn      in   1   asynchronous active-low reset
//     ibus_en     in   1   fetch request from the MMU
//     ibus_paddr  in   32  physical fetch address
//     ibus_rdata  out  32  fetched instruction, zero when not delivering
//     stallreq    out  1   fetch not yet satisfied
//     pl_stall    in   1   pipeline stalled elsewhere; hold delivered word
//     flush       in   1   discard the current fetch
//     ibuf_inv    in   1   invalidate the fetch buffer
//     m_req       out  1   master request
//     m_addr      out  32  master address
//     m_addr_ok   in   1   address accepted this cycle
//     m_data_ok   in   1   read data valid this cycle
//     m_rdata     in   32  read data
// ---------------------------------------------------------------------------
module ibus_sram_if
  import ibus_sram_if_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              ibus_en,
  input  logic [ADDR_W-1:0] ibus_paddr,
  output logic [DATA_W-1:0] ibus_rdata,
  output logic              stallreq,
  input  logic              pl_stall,
  input  logic              flush,
  input  logic              ibuf_inv,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  ibs_state_e        r_state;
  ibs_state_e        w_state_nxt;
  logic              r_discard;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;

  logic              w_idle;
  logic              w_hit;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_req;
  logic              w_deliver_bus;
  logic              w_deliver;
  logic              w_latch_addr;
  logic              w_cap_data;
  logic [DATA_W-1:0] w_cap_val;
  logic              w_set_discard;
  logic              w_clr_discard;
  logic              w_fill;

  assign w_idle = (r_state == ST_IDLE);

`ifdef IBUS_BUF_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_tag;
  logic [DATA_W-1:0] r_buf_data;

  // A flushed fetch is not served from the buffer; it is simply dropped.
  assign w_hit      = w_idle & ibus_en & ~flush & r_buf_valid & (ibus_paddr == r_buf_tag);
  assign w_buf_data = r_buf_data;

  // Invalidate has priority over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
    end else begin
      if (ibuf_inv) begin
        r_buf_valid <= 1'b0;
      end else if (w_fill) begin
        r_buf_valid <= 1'b1;
      end
      if (w_fill) begin
        r_buf_tag  <= r_addr;
        r_buf_data <= m_rdata;
      end
    end
  end
`else
  logic w_unused;
  assign w_hit      = 1'b0;
  assign w_buf_data = ZERO_WORD;
  assign w_unused   = ibuf_inv | w_fill;
`endif

  // Request raised straight from IDLE, then held through ADDR until accepted.
  assign w_req         = (w_idle & ibus_en & ~flush & ~w_hit) | (r_state == ST_ADDR);
  assign w_deliver_bus = (r_state == ST_DATA) & m_data_ok & ~r_discard & ~flush;
  assign w_deliver     = (r_state == ST_HOLD) | w_deliver_bus | w_hit;

  // Outputs are forced quiet while reset is asserted, even if the MMU is
  // still presenting a fetch.
  assign m_req    = resetn & w_req;
  assign m_addr   = w_idle ? ibus_paddr : r_addr;
  assign stallreq = resetn & ibus_en & ~w_deliver;

  always_comb begin
    ibus_rdata = ZERO_WORD;
    if (r_state == ST_HOLD) begin
      ibus_rdata = r_data;
    end else if (w_deliver_bus) begin
      ibus_rdata = m_rdata;
    end else if (w_hit) begin
      ibus_rdata = w_buf_data;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_latch_addr  = 1'b0;
    w_cap_data    = 1'b0;
    w_cap_val     = m_rdata;
    w_set_discard = 1'b0;
    w_clr_discard = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          if (pl_stall) begin
            w_state_nxt = ST_HOLD;
            w_cap_data  = 1'b1;
            w_cap_val   = w_buf_data;
          end
        end else if (w_req) begin
          // Address is kept for the whole transaction: it drives m_addr in
          // ADDR and tags the buffer fill when the data returns.
          w_latch_addr = 1'b1;
          w_state_nxt  = m_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flush) w_set_discard = 1'b1;
        if (m_addr_ok) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (m_data_ok) begin
          if (r_discard || flush) begin
            w_clr_discard = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_cap_data  = 1'b1;
            w_fill      = 1'b1;
            w_state_nxt = pl_stall ? ST_HOLD : ST_IDLE;
          end
        end else if (flush) begin
          w_set_discard = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!pl_stall || flush) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard <= 1'b0;
      r_data    <= ZERO_WORD;
      r_addr    <= '0;
    end else begin
      if (w_clr_discard) begin
        r_discard <= 1'b0;
      end else if (w_set_discard) begin
        r_discard <= 1'b1;
      end
      if (w_cap_data) r_data <= w_cap_val;
      if (w_latch_addr) r_addr <= ibus_paddr;
    end
  end

  // Read data may only return while a transaction is waiting for it.
  a_data_ok_in_data: assert property (
    @(posedge clk) disable iff (!resetn) m_data_ok |-> (r_state == ST_DATA)
  );

endmodule

// File: tb/tb_ibus_sram_if.sv
module tb_ibus_sram_if;

  logic        clk;
  logic        resetn;
  logic        ibus_en;
  logic [31:0] ibus_paddr;
  logic [31:0] ibus_rdata;
  logic        stallreq;
  logic        pl_stall;
  logic        flush;
  logic        ibuf_inv;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  int n_cmp;
  int n_err;

  ibus_sram_if dut (
    .clk        (clk),
    .resetn     (resetn),
    .ibus_en    (ibus_en),
    .ibus_paddr (ibus_paddr),
    .ibus_rdata (ibus_rdata),
    .stallreq   (stallreq),
    .pl_stall   (pl_stall),
    .flush      (flush),
    .ibuf_inv   (ibuf_inv),
    .m_req      (m_req),
    .m_addr     (m_addr),
    .m_addr_ok  (m_addr_ok),
    .m_data_ok  (m_data_ok),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ibus_en = 1'b0; ibus_paddr = 32'h0; pl_stall = 1'b0;
    flush = 1'b0; ibuf_inv = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    m_rdata = 32'h0;
    #2;
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL reset_m_req got %b want 0", m_req); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got %b want 0", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 00000000", ibus_rdata); end
    #10 resetn = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00000; m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL zw_req got %b want 1", m_req); end
    n_cmp++; if (m_addr !== 32'h1FC00000) begin n_err++; $display("FAIL zw_addr got %h want 1fc00000", m_addr); end
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL zw_stall0 got %b want 1", stallreq); end
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h3C1D0001;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL zw_stall1 got %b want 0", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h3C1D0001) begin n_err++; $display("FAIL zw_rdata got %h want 3c1d0001", ibus_rdata); end
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL zw_req_data got %b want 0", m_req); end
    tick();
    m_data_ok = 1'b0; ibus_en = 1'b0;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h0) begin n_err++; $display("FAIL zw_idle_rdata got %h want 00000000", ibus_rdata); end
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL zw_idle_req got %b want 0", m_req); end
  endtask

  task automatic test_slow_memory();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00010; m_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL slow_req[%0d] got %b want 1", i, m_req); end
      n_cmp++; if (m_addr !== 32'h1FC00010) begin n_err++; $display("FAIL slow_addr[%0d] got %h want 1fc00010", i, m_addr); end
      n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL slow_stall[%0d] got %b want 1", i, stallreq); end
      tick();
      // The MMU side changing must not disturb a pending request.
      ibus_paddr = 32'hAAAA0000 + i;
    end
    m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (m_addr !== 32'h1FC00010) begin n_err++; $display("FAIL slow_addr_ok got %h want 1fc00010", m_addr); end
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL slow_req_ok got %b want 1", m_req); end
    tick();
    m_addr_ok = 1'b0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL slow_stall_data got %b want 1", stallreq); end
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL slow_req_data got %b want 0", m_req); end
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h11112222;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL slow_stall_done got %b want 0", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h11112222) begin n_err++; $display("FAIL slow_rdata got %h want 11112222", ibus_rdata); end
    tick();
    m_data_ok = 1'b0; ibus_en = 1'b0;
  endtask

  task automatic test_hold();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00020; m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h8FBF0018; pl_stall = 1'b1;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h8FBF0018) begin n_err++; $display("FAIL hold_deliver got %h want 8fbf0018", ibus_rdata); end
    tick();
    m_data_ok = 1'b0; m_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      pl_stall = (i < 3);
      #1;
      n_cmp++; if (ibus_rdata !== 32'h8FBF0018) begin n_err++; $display("FAIL hold_rdata[%0d] got %h want 8fbf0018", i, ibus_rdata); end
      n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL hold_stall[%0d] got %b want 0", i, stallreq); end
      n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] got %b want 0", i, m_req); end
      tick();
    end
    ibus_en = 1'b0;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h0) begin n_err++; $display("FAIL hold_idle_rdata got %h want 00000000", ibus_rdata); end
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00024;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL hold_idle_req got %b want 1", m_req); end
    ibus_en = 1'b0;
    tick();
  endtask

  task automatic test_flush_in_addr();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00030; m_addr_ok = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL flush_req_held got %b want 1", m_req); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL flush_req_after got %b want 1", m_req); end
    n_cmp++; if (m_addr !== 32'h1FC00030) begin n_err++; $display("FAIL flush_addr got %h want 1fc00030", m_addr); end
    tick();
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hBAD0BAD0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL flush_drop_stall got %b want 1", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h0) begin n_err++; $display("FAIL flush_drop_rdata got %h want 00000000", ibus_rdata); end
    tick();
    m_data_ok = 1'b0; ibus_paddr = 32'hBFC00380; m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL flush_next_req got %b want 1", m_req); end
    n_cmp++; if (m_addr !== 32'hBFC00380) begin n_err++; $display("FAIL flush_next_addr got %h want bfc00380", m_addr); end
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h24020001;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h24020001) begin n_err++; $display("FAIL flush_next_rdata got %h want 24020001", ibus_rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL flush_next_stall got %b want 0", stallreq); end
    tick();
    m_data_ok = 1'b0; ibus_en = 1'b0;
  endtask

  task automatic test_async_reset();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00040; m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL arst_req got %b want 0", m_req); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL arst_stall got %b want 0", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h0) begin n_err++; $display("FAIL arst_rdata got %h want 00000000", ibus_rdata); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    ibus_paddr = 32'h1FC00044; m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL arst_next_req got %b want 1", m_req); end
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h3C080000;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h3C080000) begin n_err++; $display("FAIL arst_next_rdata got %h want 3c080000", ibus_rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL arst_next_stall got %b want 0", stallreq); end
    tick();
    m_data_ok = 1'b0; ibus_en = 1'b0;
  endtask

`ifdef IBUS_BUF_EN
  task automatic test_fetch_buffer();
    ibus_en = 1'b1; ibus_paddr = 32'h1FC00004; m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h27BDFFE0;
    #1;
    n_cmp++; if (ibus_rdata !== 32'h27BDFFE0) begin n_err++; $display("FAIL buf_fill_rdata got %h want 27bdffe0", ibus_rdata); end
    tick();
    m_data_ok = 1'b0; m_rdata = 32'h0;
    #1;
    n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL buf_hit_req got %b want 0", m_req); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL buf_hit_stall got %b want 0", stallreq); end
    n_cmp++; if (ibus_rdata !== 32'h27BDFFE0) begin n_err++; $display("FAIL buf_hit_rdata got %h want 27bdffe0", ibus_rdata); end
    tick();
    ibus_en = 1'b0; ibuf_inv = 1'b1;
    tick();
    ibuf_inv = 1'b0; ibus_en = 1'b1; m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL buf_inv_req got %b want 1", m_req); end
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL buf_inv_stall got %b want 1", stallreq); end
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h27BDFFE0;
    tick();
    m_data_ok = 1'b0; ibus_en = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_zero_wait();
    test_slow_memory();
    test_hold();
    test_flush_in_addr();
    test_async_reset();
`ifdef IBUS_BUF_EN
    test_fetch_buffer();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
